// File: rtl/lut_neuron_loader_if.sv
// rtl/lut_neuron_loader_if.sv - config, lookup and result handshakes of the LUT neuron loader
interface lut_neuron_loader_if #(
    parameter int IN_BITS   = 8,
    parameter int OUT_BITS  = 1,
    parameter int CFG_WIDTH = 8
);
    localparam int NWORDS = ((1 << IN_BITS) * OUT_BITS) / CFG_WIDTH;
    localparam int CW     = $clog2(NWORDS) + 1;

    logic                 cfg_start;
    logic                 cfg_valid;
    logic [CFG_WIDTH-1:0] cfg_data;
    logic                 cfg_ready;
    logic [CW-1:0]        cfg_count;
    logic                 loaded;
    logic                 lk_valid;
    logic [IN_BITS-1:0]   lk_addr;
    logic                 lk_ready;
    logic                 res_valid;
    logic [OUT_BITS-1:0]  res_data;
    logic                 res_ready;

    // Config source / lookup client side
    modport master (
        output cfg_start, cfg_valid, cfg_data, lk_valid, lk_addr, res_ready,
        input  cfg_ready, cfg_count, loaded, lk_ready, res_valid, res_data
    );

    // Neuron table side
    modport slave (
        input  cfg_start, cfg_valid, cfg_data, lk_valid, lk_addr, res_ready,
        output cfg_ready, cfg_count, loaded, lk_ready, res_valid, res_data
    );
endinterface

// File: rtl/lut_neuron_loader.sv
// rtl/lut_neuron_loader.sv - runtime-loadable LUT neuron truth table with handshaked lookups
module lut_neuron_loader #(
    parameter int IN_BITS   = 8,
    parameter int OUT_BITS  = 1,
    parameter int CFG_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    lut_neuron_loader_if.slave bus
);
    localparam int NENT   = 1 << IN_BITS;
    localparam int NBITS  = NENT * OUT_BITS;
    localparam int NWORDS = NBITS / CFG_WIDTH;
    localparam int CW     = $clog2(NWORDS) + 1;

    typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

    state_t              state_q;
    logic [CW-1:0]       cfg_count_q;
    logic                loaded_q;
    logic                res_valid_q;
    logic [OUT_BITS-1:0] res_data_q;
    logic [NBITS-1:0]    table_q;
    logic [OUT_BITS-1:0] entry [NENT];

    logic cfg_ready;
    logic lk_ready;
    logic cfg_fire;
    logic lk_fire;

    // Ready terms come only from state, cfg_start and the result handshake
    always_comb begin
        cfg_ready = (state_q == LOAD) && !bus.cfg_start;
        lk_ready  = (state_q == READY) && !bus.cfg_start && (!res_valid_q || bus.res_ready);
        cfg_fire  = cfg_ready && bus.cfg_valid;
        lk_fire   = lk_ready && bus.lk_valid;
    end

    // Slice the flat table into entries so lookups index an array directly
    always_comb begin
        for (int e = 0; e < NENT; e++) begin
            entry[e] = table_q[e*OUT_BITS +: OUT_BITS];
        end
    end

    // Table storage is never cleared; an accepted word lands at its word slot
    always_ff @(posedge clk) begin
        for (int w = 0; w < NWORDS; w++) begin
            if (rst_n && cfg_fire && cfg_count_q == CW'(w)) begin
                table_q[w*CFG_WIDTH +: CFG_WIDTH] <= bus.cfg_data;
            end
        end
    end

    // Load FSM plus the single-entry result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            cfg_count_q <= '0;
            loaded_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            // A pending result survives a reload; only a consume or a new accept moves it
            if (lk_fire) begin
                res_valid_q <= 1'b1;
                res_data_q  <= entry[bus.lk_addr];
            end else if (bus.res_ready) begin
                res_valid_q <= 1'b0;
            end

            case (state_q)
                EMPTY: begin
                    if (bus.cfg_start) begin
                        state_q     <= LOAD;
                        cfg_count_q <= '0;
                    end
                end
                LOAD: begin
                    if (bus.cfg_start) begin
                        cfg_count_q <= '0;
                    end else if (cfg_fire) begin
                        cfg_count_q <= cfg_count_q + CW'(1);
                        if (cfg_count_q == CW'(NWORDS - 1)) begin
                            state_q  <= READY;
                            loaded_q <= 1'b1;
                        end
                    end
                end
                READY: begin
                    if (bus.cfg_start) begin
                        state_q     <= LOAD;
                        loaded_q    <= 1'b0;
                        cfg_count_q <= '0;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign bus.cfg_ready = cfg_ready;
    assign bus.lk_ready  = lk_ready;
    assign bus.cfg_count = cfg_count_q;
    assign bus.loaded    = loaded_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
endmodule

// File: doc/lut_neuron_loader.md
# lut_neuron_loader

Runtime-programmable LUT neuron for the LogicNets MNIST ensemble. It is the writer side of the per-neuron truth-table ROMs: a configuration stream loads the 2^IN_BITS-entry truth table into internal registers, and the block then answers registered, handshaked lookups from the same table. It sits between the weight/config DMA and a layer's neuron array, so that table contents can change without resynthesis.

## Interface
Parameters:
- IN_BITS, 8, neuron fan-in bits; the table holds 2^IN_BITS entries.
- OUT_BITS, 1, width of each table entry.
- CFG_WIDTH, 8, config word width; must divide 2^IN_BITS*OUT_BITS. NWORDS = 2^IN_BITS*OUT_BITS/CFG_WIDTH (32 at defaults).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cfg_start  in  1  single-cycle pulse; begins or restarts a table load.
- cfg_valid  in  1  config word valid.
- cfg_data  in  CFG_WIDTH  config word.
- cfg_ready  out  1  config word accepted when cfg_valid&cfg_ready.
- cfg_count  out  $clog2(NWORDS)+1  number of words accepted in the current load.
- loaded  out  1  table holds a complete, valid image.
- lk_valid  in  1  lookup request valid.
- lk_addr  in  IN_BITS  lookup index (M0 value as an unsigned integer).
- lk_ready  out  1  lookup accepted when lk_valid&lk_ready.
- res_valid  out  1  result valid.
- res_data  out  OUT_BITS  table entry (M1).
- res_ready  in  1  result consumed when res_valid&res_ready.

## Operation
- States: EMPTY (reset state, no image), LOAD, READY.
- EMPTY: cfg_start -> LOAD. All other inputs ignored.
- LOAD: cfg_ready=1. Accepted word k (0-based) writes bits [k*CFG_WIDTH +: CFG_WIDTH] of the flat table; flat bit e*OUT_BITS+b is bit b of entry e. cfg_count increments per accepted word. The accept of word NWORDS-1 -> READY and loaded=1 on the next cycle.
- cfg_start in LOAD: cfg_count clears to 0 and the load restarts. The word presented in the same cycle is NOT accepted (cfg_ready=0 in any cycle that has cfg_start).
- READY: cfg_ready=0. lk_ready = !res_valid | res_ready. cfg_start -> LOAD and loaded=0 on the next cycle, and cfg_count clears.
- Lookups are accepted only in READY. lk_ready=0 in EMPTY and LOAD, and in a cycle that has cfg_start.
- A result that is pending when a load starts stays valid and unchanged until consumed.
- Table bits that have not been written keep their previous contents. loaded is the only validity indicator.
- Reset values: state=EMPTY, loaded=0, cfg_count=0, cfg_ready=0, lk_ready=0, res_valid=0, res_data=0. Table contents are not reset.
- Reset mid-load or mid-lookup: all of the above take effect on the next edge, and any pending result is dropped.

## Timing
- Config throughput: 1 word/cycle. The minimum load is NWORDS cycles after the cfg_start cycle. loaded rises 1 cycle after the last accept.
- Lookup latency: 1 cycle. An accept at edge n gives res_valid=1 with res_data=table[lk_addr] after edge n.
- Lookup throughput: 1/cycle while res_ready=1. The output register holds its value under backpressure (res_ready=0), and lk_ready drops combinationally in that case.
- Simultaneous res_ready and a new accept in the same cycle: the old result retires and the new result loads. No bubble.
- cfg_ready and lk_ready depend only on registered state and on cfg_start, res_valid and res_ready. No path from lk_valid or cfg_valid to a ready output.

## Test plan
- Lookup before load: after reset, lk_valid=1 for 10 cycles -> lk_ready=0, res_valid=0, loaded=0 throughout.
- Full load and sweep: cfg_start, then 32 words with word k = k*8+1 (mod 256), then lookups on addresses 0..255 back to back with res_ready=1 -> loaded=1 one cycle after word 31, and each res_data matches bit (a%8) of word a/8, one per cycle.
- Backpressure: loaded table, res_ready=0 for 5 cycles after the first result -> res_data held, lk_ready=0. Release -> the next addresses stream with no loss or duplication.
- Restart mid-load: cfg_start, 10 words of 0xFF, cfg_start with cfg_valid=1, then 32 words of 0x00 -> the word in the restart cycle is not accepted, cfg_count reaches 32, and all lookups return 0.
- Reload from READY with a pending result: result for address 5 pending with res_ready=0, then cfg_start -> res_valid stays 1 with the original data, loaded=0 next cycle, and lk_ready=0 until the new load completes.
- Reset mid-load: rst_n=0 for one cycle after 12 words -> state EMPTY, cfg_count=0, loaded=0, cfg_ready=0. A subsequent full load then operates normally.
